// File: rtl/gcd_dispatch_pkg.sv
// ============================================================
// gcd_pkg : shared types and helpers for the GCD dispatcher
// Rev 1.0
// ============================================================
`default_nettype none

package gcd_pkg;

  localparam int c_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; used with +1 for counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_dispatch_if.sv
// ============================================================
// gcd_dispatch_if : operand stream, result stream and GCD link
// Rev 1.0
// ============================================================
`default_nettype none

interface gcd_dispatch_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  import gcd_pkg::*;

  localparam int c_CNT_W = clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic             out_error;
  logic             out_timeout;
  logic [TAG_W-1:0] out_tag;
  logic             gcd_start;
  logic [W-1:0]     gcd_a;
  logic [W-1:0]     gcd_b;
  logic [W-1:0]     gcd_y;
  logic             gcd_error;
  logic             gcd_done;
  logic             busy;
  logic [c_CNT_W-1:0] count;

  // Dispatcher side
  modport slave (
    input  in_valid, in_a, in_b, out_ready, gcd_y, gcd_error, gcd_done,
    output in_ready, out_valid, out_y, out_error, out_timeout, out_tag,
           gcd_start, gcd_a, gcd_b, busy, count
  );

  // Producer / consumer / GCD engine side
  modport master (
    output in_valid, in_a, in_b, out_ready, gcd_y, gcd_error, gcd_done,
    input  in_ready, out_valid, out_y, out_error, out_timeout, out_tag,
           gcd_start, gcd_a, gcd_b, busy, count
  );

endinterface

`default_nettype wire

// File: rtl/gcd_dispatch_fifo.sv
// ============================================================
// gcd_dispatch_fifo : synchronous show-ahead FIFO for job entries
// Rev 1.0
// ============================================================
`default_nettype none

module gcd_dispatch_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 20
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          i_push,
  input  wire logic                          i_pop,
  input  wire logic [DATA_W-1:0]             i_data,
  output logic      [DATA_W-1:0]             o_data,
  output logic      [clog2(DEPTH+1)-1:0]     o_count,
  output logic                               o_full,
  output logic                               o_empty
);

  localparam int c_PTR_W = clog2(DEPTH);
  localparam int c_CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/gcd_dispatch.sv
// ============================================================
// gcd_dispatch : buffers operand pairs and issues them to the GCD
// Rev 1.0
// ============================================================
`default_nettype none

module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int W       = c_W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  wire logic       clk,
  input  wire logic       rst,
  gcd_dispatch_if.slave   bus
);

  localparam int c_CNT_W   = clog2(DEPTH + 1);
  localparam int c_TO_W    = clog2(TIMEOUT + 1);
  localparam int c_ENTRY_W = 2 * W + TAG_W;

  state_t             r_state;
  state_t             w_state_next;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_job_tag;
  logic [W-1:0]       r_gcd_a;
  logic [W-1:0]       r_gcd_b;
  logic [W-1:0]       r_out_y;
  logic               r_out_error;
  logic               r_out_timeout;
  logic               r_done_q;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic [c_TO_W-1:0]  w_to_cnt_next;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_done_edge;
  logic               w_timeout_hit;
  logic               w_cap_done;
  logic               w_cap_timeout;
  logic [c_ENTRY_W-1:0] w_fifo_wdata;
  logic [c_ENTRY_W-1:0] w_fifo_rdata;
  logic [c_CNT_W-1:0] w_count;

  assign w_push       = bus.in_valid & ~w_full;
  assign w_fifo_wdata = {r_tag, bus.in_a, bus.in_b};

  gcd_dispatch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (c_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_wdata),
    .o_data  (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A DONE level held over from a previous job yields no edge here.
  assign w_done_edge   = bus.gcd_done & ~r_done_q;
  assign w_to_cnt_next = (r_to_cnt == c_TO_W'(TIMEOUT)) ? r_to_cnt
                                                        : r_to_cnt + c_TO_W'(1);
  assign w_timeout_hit = (w_to_cnt_next == c_TO_W'(TIMEOUT));

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_cap_done    = 1'b0;
    w_cap_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_edge) begin
          w_cap_done   = 1'b1;
          w_state_next = ST_RESULT;
        end else if (w_timeout_hit) begin
          w_cap_timeout = 1'b1;
          w_state_next  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tag         <= '0;
      r_job_tag     <= '0;
      r_gcd_a       <= '0;
      r_gcd_b       <= '0;
      r_out_y       <= '0;
      r_out_error   <= 1'b0;
      r_out_timeout <= 1'b0;
      r_done_q      <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state  <= w_state_next;
      r_done_q <= bus.gcd_done;
      if (w_push) r_tag <= r_tag + TAG_W'(1);
      if (w_pop) {r_job_tag, r_gcd_a, r_gcd_b} <= w_fifo_rdata;
      if (r_state == ST_ISSUE)     r_to_cnt <= '0;
      else if (r_state == ST_WAIT) r_to_cnt <= w_to_cnt_next;
      if (w_cap_done) begin
        r_out_y       <= bus.gcd_y;
        r_out_error   <= bus.gcd_error;
        r_out_timeout <= 1'b0;
      end else if (w_cap_timeout) begin
        r_out_y       <= '0;
        r_out_error   <= 1'b0;
        r_out_timeout <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = ~w_full;
  assign bus.out_valid   = (r_state == ST_RESULT);
  assign bus.out_y       = r_out_y;
  assign bus.out_error   = r_out_error;
  assign bus.out_timeout = r_out_timeout;
  assign bus.out_tag     = r_job_tag;
  assign bus.gcd_start   = (r_state == ST_ISSUE);
  assign bus.gcd_a       = r_gcd_a;
  assign bus.gcd_b       = r_gcd_b;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.count       = w_count;

endmodule

`default_nettype wire

// File: tb/tb_gcd_dispatch.sv
// ============================================================
// tb_gcd_dispatch : directed self-checking bench with a GCD model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_gcd_dispatch;
  import gcd_pkg::*;

  localparam int W = 8, DEPTH = 4, TAG_W = 4, TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  gcd_dispatch_if #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  gcd_dispatch #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // GCD engine model: fixed latency, DONE level until the next START
  logic         m_done  = 1'b0;
  logic         m_err   = 1'b0;
  logic [W-1:0] m_y     = '0;
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_b     = '0;
  logic         m_run   = 1'b0;
  int           m_lat   = 0;
  logic         never_done = 1'b0;

  assign bus.gcd_done  = m_done;
  assign bus.gcd_error = m_err;
  assign bus.gcd_y     = m_y;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    if (a == 0 || b == 0) return '0;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge clk) begin
    if (bus.gcd_start) begin
      m_a <= bus.gcd_a; m_b <= bus.gcd_b; m_lat <= 3; m_run <= 1'b1; m_done <= 1'b0;
    end else if (m_run) begin
      if (never_done) m_run <= 1'b0;
      else if (m_lat == 0) begin
        m_done <= 1'b1;
        m_y    <= ref_gcd(m_a, m_b);
        m_err  <= (m_a == 0 || m_b == 0);
        m_run  <= 1'b0;
      end else m_lat <= m_lat - 1;
    end
  end

  // Start pulse counter and operand-hold monitor
  int           start_cnt = 0;
  int           hold_viol = 0;
  logic         tracking  = 1'b0;
  logic [W-1:0] ha = '0, hb = '0;

  always @(negedge clk) begin
    if (rst) tracking <= 1'b0;
    else if (bus.gcd_start) begin
      start_cnt <= start_cnt + 1;
      ha <= bus.gcd_a; hb <= bus.gcd_b; tracking <= 1'b1;
    end else if (tracking) begin
      if (!bus.busy) tracking <= 1'b0;
      else if (bus.gcd_a != ha || bus.gcd_b != hb) hold_viol <= hold_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    g = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    while (!bus.in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) check("push_timeout", 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input int ey, input int ee,
                            input int et, input int etag);
    int g;
    g = 0;
    while (!bus.out_valid && g < 1000) begin @(negedge clk); g++; end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_y"}, bus.out_y, ey);
    check({name, "_err"}, bus.out_error, ee);
    check({name, "_to"}, bus.out_timeout, et);
    check({name, "_tag"}, bus.out_tag, etag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s, n, cyc;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_start", bus.gcd_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.count, 0);
    check("rst_gcd_a", bus.gcd_a, 0);
    check("rst_out_y", bus.out_y, 0);

    // Single job: latency and a single start pulse
    bus.out_ready = 1'b1;
    s = start_cnt;
    push(21, 6);
    n = 0;
    while (!bus.gcd_start && n < 10) begin @(negedge clk); n++; end
    check("start_latency", n, 1);
    get_result("j21_6", 3, 0, 0, 0);
    @(negedge clk);
    check("one_start", start_cnt - s, 1);

    // Fill the FIFO while the first result is stalled
    do_reset();
    bus.out_ready = 1'b0;
    push(75, 60);
    push(29, 8);
    push(103, 103);
    push(99, 11);
    check("count_3", bus.count, 3);
    check("ready_3", bus.in_ready, 1);
    push(12, 18);
    check("count_full", bus.count, 4);
    check("ready_full", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_a = 1; bus.in_b = 1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("count_refused", bus.count, 4);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    s = start_cnt;
    repeat (10) @(negedge clk);
    check("stall_valid", bus.out_valid, 1);
    check("stall_y", bus.out_y, 15);
    check("stall_tag", bus.out_tag, 0);
    check("stall_no_start", start_cnt - s, 0);
    bus.out_ready = 1'b1;
    get_result("q0", 15, 0, 0, 0);
    get_result("q1", 1, 0, 0, 1);
    get_result("q2", 103, 0, 0, 2);
    get_result("q3", 11, 0, 0, 3);
    get_result("q4", 6, 0, 0, 4);
    check("operand_hold", hold_viol, 0);

    // GCD error flag
    push(0, 5);
    get_result("err", 0, 1, 0, 5);

    // Timeout: DONE never rises
    never_done = 1'b1;
    push(8, 12);
    n = 0;
    while (!bus.gcd_start && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    cyc = 0;
    while (!bus.out_valid && cyc < 400) begin @(negedge clk); cyc++; end
    check("timeout_cycles", cyc, 255);
    get_result("tmo", 0, 0, 1, 6);
    never_done = 1'b0;
    push(12, 8);
    get_result("after_tmo", 4, 0, 0, 7);

    // Reset in WAIT with two entries queued
    never_done = 1'b1;
    push(9, 3);
    push(5, 5);
    push(6, 6);
    check("queued_count", bus.count, 2);
    check("queued_busy", bus.busy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_start", bus.gcd_start, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    never_done = 1'b0;
    push(14, 21);
    get_result("post_rst", 7, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
